// File: rtl/ca_linear_regression_if.sv
// rtl/ca_linear_regression_if.sv - sample-in / residual-out bundle for the regression engine
interface ca_linear_regression_if #(
  parameter int W = 20
);
  logic                start;
  logic signed [W-1:0] in_x;
  logic signed [W-1:0] in_y;
  logic                ready;
  logic signed [W-1:0] error_out;
  logic                error_ready;

  modport master (output start, in_x, in_y, input ready, error_out, error_ready);
  modport slave  (input start, in_x, in_y, output ready, error_out, error_ready);
endinterface

// File: rtl/ca_linear_regression.sv
// rtl/ca_linear_regression.sv - streaming least-squares line fit with per-sample residual output
module ca_linear_regression #(
  parameter int N    = 150,
  parameter int W    = 20,
  parameter int FRAC = 10
) (
  input logic                   clk,
  input logic                   reset,
  ca_linear_regression_if.slave bus
);
  localparam int AW       = 28;
  localparam int SW       = 48;
  localparam int DW       = SW + FRAC;
  localparam int EW       = 2 * W + 2;
  localparam int IW       = $clog2(N);
  localparam int MEAN_END = 2 * DW + 2;
  localparam int CW       = $clog2(((N > MEAN_END) ? N : MEAN_END) + 1);
  localparam logic signed [EW-1:0] L_MAX = EW'((2 ** (W - 1)) - 1);
  localparam logic signed [EW-1:0] L_MIN = -L_MAX - EW'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MEAN, S_VAR, S_DIV, S_B0, S_OUT} state_t;

  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_ready, r_eready;
  logic signed [W-1:0]  r_eout, r_xm, r_ym, r_b1, r_b0;
  logic signed [AW-1:0] r_sx, r_sy;
  logic signed [SW-1:0] r_sxy, r_sxx;
  logic signed [W-1:0]  r_ram_x [N];
  logic signed [W-1:0]  r_ram_y [N];
  logic [DW-1:0]        r_dq;
  logic [SW-1:0]        r_drem, r_dden;
  logic                 r_dneg;

  logic [IW-1:0]         w_ridx, w_widx;
  logic signed [W-1:0]   w_rx, w_ry;
  logic signed [W:0]     w_dx, w_dy;
  logic signed [2*W+1:0] w_pxy, w_pxx;
  logic signed [EW-1:0]  w_res, w_b0_full;
  logic [AW-1:0]         w_sx_abs, w_sy_abs;
  logic [SW-1:0]         w_sxy_abs;
  logic                  w_dload, w_dneg;
  logic [DW-1:0]         w_dnum;
  logic [SW-1:0]         w_dden;
  logic [SW:0]           w_rsh, w_rsub;
  logic signed [W-1:0]   w_dsat;

  function automatic logic signed [W-1:0] sat_w(input logic signed [EW-1:0] v);
    if (v > L_MAX) return {1'b0, {(W - 1){1'b1}}};
    if (v < L_MIN) return {1'b1, {(W - 1){1'b0}}};
    return v[W-1:0];
  endfunction

  assign w_ridx    = r_cnt[IW-1:0];
  assign w_widx    = w_ridx - IW'(1);
  assign w_rx      = r_ram_x[w_ridx];
  assign w_ry      = r_ram_y[w_ridx];
  assign w_dx      = (W + 1)'(w_rx) - (W + 1)'(r_xm);
  assign w_dy      = (W + 1)'(w_ry) - (W + 1)'(r_ym);
  assign w_pxy     = w_dx * w_dy;
  assign w_pxx     = w_dx * w_dx;
  assign w_b0_full = EW'(r_ym) - ((EW'(r_b1) * EW'(r_xm)) >>> FRAC);
  assign w_res     = EW'(w_ry) - EW'(r_b0) - ((EW'(r_b1) * EW'(w_rx)) >>> FRAC);
  assign w_sx_abs  = r_sx[AW-1] ? -r_sx : r_sx;
  assign w_sy_abs  = r_sy[AW-1] ? -r_sy : r_sy;
  assign w_sxy_abs = r_sxy[SW-1] ? -r_sxy : r_sxy;
  assign w_rsh     = {r_drem, r_dq[DW-1]};
  assign w_rsub    = w_rsh - {1'b0, r_dden};

  assign bus.ready       = r_ready;
  assign bus.error_out   = r_eout;
  assign bus.error_ready = r_eready;

  // Divider operand select: Sx then Sy during MEAN, scaled Sxy over Sxx at the start of DIV
  always_comb begin
    w_dload = 1'b0;
    w_dnum  = '0;
    w_dden  = SW'(N);
    w_dneg  = 1'b0;
    if (r_state == S_MEAN && r_cnt == '0) begin
      w_dload = 1'b1;
      w_dnum  = DW'(w_sx_abs);
      w_dneg  = r_sx[AW-1];
    end else if (r_state == S_MEAN && r_cnt == CW'(DW + 1)) begin
      w_dload = 1'b1;
      w_dnum  = DW'(w_sy_abs);
      w_dneg  = r_sy[AW-1];
    end else if (r_state == S_DIV && r_cnt == '0) begin
      w_dload = 1'b1;
      w_dnum  = {w_sxy_abs, {FRAC{1'b0}}};
      w_dden  = r_sxx;
      w_dneg  = r_sxy[SW-1];
    end
  end

  // Apply the quotient sign (truncation toward zero) and clamp to the W-bit range
  always_comb begin
    w_dsat = '0;
    if (r_dneg)
      w_dsat = (r_dq > DW'(2 ** (W - 1))) ? {1'b1, {(W - 1){1'b0}}} : -r_dq[W-1:0];
    else
      w_dsat = (r_dq > DW'((2 ** (W - 1)) - 1)) ? {1'b0, {(W - 1){1'b1}}} : r_dq[W-1:0];
  end

  // Restoring divider on magnitudes: one quotient bit shifted in per cycle, DW steps per divide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dq   <= '0;
      r_drem <= '0;
      r_dden <= '0;
      r_dneg <= 1'b0;
    end else if (w_dload) begin
      r_dq   <= w_dnum;
      r_drem <= '0;
      r_dden <= w_dden;
      r_dneg <= w_dneg;
    end else if (r_state == S_MEAN || r_state == S_DIV) begin
      r_dq   <= {r_dq[DW-2:0], ~w_rsub[SW]};
      r_drem <= w_rsub[SW] ? w_rsh[SW-1:0] : w_rsub[SW-1:0];
    end
  end

  // Sample store, written on capture edges only (the settle edge has r_cnt == 0)
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && r_cnt != '0) begin
      r_ram_x[w_widx] <= bus.in_x;
      r_ram_y[w_widx] <= bus.in_y;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: each phase ends on a fixed counter value, so run length is data-independent
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_LOAD;
      S_LOAD: if (r_cnt == CW'(N)) w_next = S_MEAN;
      S_MEAN: if (r_cnt == CW'(MEAN_END)) w_next = S_VAR;
      S_VAR:  if (r_cnt == CW'(N - 1)) w_next = S_DIV;
      S_DIV:  if (r_cnt == CW'(DW + 1)) w_next = S_B0;
      S_B0:   w_next = S_OUT;
      S_OUT:  if (r_cnt == CW'(N - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: accumulation, mean/slope capture, intercept and residual registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_ready  <= 1'b0;
      r_eready <= 1'b0;
      r_eout   <= '0;
      r_xm     <= '0;
      r_ym     <= '0;
      r_b1     <= '0;
      r_b0     <= '0;
      r_sx     <= '0;
      r_sy     <= '0;
      r_sxy    <= '0;
      r_sxx    <= '0;
    end else begin
      r_eready <= (r_state == S_OUT);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_sx  <= '0;
          r_sy  <= '0;
          r_sxy <= '0;
          r_sxx <= '0;
          if (bus.start) r_ready <= 1'b1;
        end
        S_LOAD: begin
          if (r_cnt != '0) begin
            r_sx <= r_sx + AW'(bus.in_x);
            r_sy <= r_sy + AW'(bus.in_y);
          end
          if (r_cnt == CW'(N)) begin
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_MEAN: begin
          if (r_cnt == CW'(DW + 1)) r_xm <= w_dsat;
          if (r_cnt == CW'(MEAN_END)) begin
            r_ym  <= w_dsat;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_VAR: begin
          r_sxy <= r_sxy + SW'(w_pxy);
          r_sxx <= r_sxx + SW'(w_pxx);
          r_cnt <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + 1'b1;
        end
        S_DIV: begin
          if (r_cnt == CW'(DW + 1)) begin
            r_b1  <= (r_sxx == '0) ? '0 : w_dsat;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_B0: r_b0 <= sat_w(w_b0_full);
        S_OUT: begin
          r_eout <= sat_w(w_res);
          r_cnt  <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ca_linear_regression.sv
// tb/tb_ca_linear_regression.sv - randomized bench against a least-squares reference model
`timescale 1ns/1ps
module tb_ca_linear_regression;
  localparam int N      = 150;
  localparam int W      = 20;
  localparam int FRAC   = 10;
  localparam int BUDGET = 2000;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ca_linear_regression_if #(.W(W)) bus ();
  ca_linear_regression #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     n_checks = 0;
  int     n_pass   = 0;
  longint mx [N];
  longint my [N];
  longint ex [N];
  longint ge [N];
  int     got_n;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic longint sat(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // Least-squares fit straight from the formulas, in 64-bit integer arithmetic
  task automatic model();
    longint sx = 0, sy = 0, sxy = 0, sxx = 0;
    longint xm, ym, b1, b0;
    for (int k = 0; k < N; k++) begin
      sx += mx[k];
      sy += my[k];
    end
    xm = sx / N;
    ym = sy / N;
    for (int k = 0; k < N; k++) begin
      sxy += (mx[k] - xm) * (my[k] - ym);
      sxx += (mx[k] - xm) * (mx[k] - xm);
    end
    b1 = (sxx == 0) ? 0 : sat((sxy * 1024) / sxx);
    b0 = sat(ym - ((b1 * xm) >>> FRAC));
    for (int k = 0; k < N; k++)
      ex[k] = sat(my[k] - b0 - ((b1 * mx[k]) >>> FRAC));
  endtask

  task automatic feed(input bit pulse);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in_x  = W'($urandom);
    bus.in_y  = W'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ready_rise", bus.ready, 1);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      bus.in_x  = W'(mx[k]);
      bus.in_y  = W'(my[k]);
      bus.start = (pulse && (k == 40));
      if (k == 0 || k == N - 1) chk($sformatf("ready_k%0d", k), bus.ready, 1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_x  = W'($urandom);
    bus.in_y  = W'($urandom);
    chk("ready_fall", bus.ready, 0);
  endtask

  task automatic collect(input string tag, input bit pulse);
    got_n = 0;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.error_ready) begin
        chk({tag, ".overlap"}, bus.ready, 0);
        if (got_n < N) begin
          ge[got_n] = bus.error_out;
          chk($sformatf("%s.e%0d", tag, got_n), bus.error_out, ex[got_n]);
        end
        got_n++;
        if (pulse && got_n == 20) bus.start = 1'b1;
      end else if (got_n > 0) begin
        break;
      end
    end
    chk({tag, ".count"}, got_n, N);
    repeat (4) @(negedge clk);
    chk({tag, ".idle_ready"}, bus.ready, 0);
    chk({tag, ".idle_eready"}, bus.error_ready, 0);
    chk({tag, ".hold"}, bus.error_out, ex[N-1]);
  endtask

  task automatic run(input string tag, input bit pulse);
    model();
    feed(pulse);
    collect(tag, pulse);
  endtask

  initial begin
    int nz;
    int busy;
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.in_x  = '0;
    bus.in_y  = '0;
    repeat (3) @(negedge clk);
    chk("rst.ready", bus.ready, 0);
    chk("rst.eready", bus.error_ready, 0);
    chk("rst.eout", bus.error_out, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < N; k++) begin
      mx[k] = k * 1024;
      my[k] = 2 * mx[k] + 1024;
    end
    run("lin", 1'b0);
    nz = 0;
    for (int k = 0; k < N; k++) if (ge[k] != 0) nz++;
    chk("lin.nonzero", nz, 0);

    for (int k = 0; k < N; k++) begin
      mx[k] = 3072;
      my[k] = k * 1024;
    end
    run("flat", 1'b0);
    chk("flat.e0", ge[0], -76288);
    chk("flat.elast", ge[N-1], 76288);

    for (int k = 0; k < N; k++) begin
      mx[k] = longint'($urandom_range(0, 65535)) - 32768;
      my[k] = longint'($urandom_range(0, 65535)) - 32768;
    end
    feed(1'b0);
    repeat (130) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2.ready", bus.ready, 0);
    chk("rst2.eready", bus.error_ready, 0);
    chk("rst2.eout", bus.error_out, 0);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ready || bus.error_ready) busy++;
    end
    chk("rst2.idle", busy, 0);

    for (int k = 0; k < N; k++) begin
      mx[k] = k * 1024;
      my[k] = mx[k] + ((k % 2 == 0) ? 512 : -512);
    end
    run("alt", 1'b0);

    for (int k = 0; k < N; k++) begin
      mx[k] = longint'($urandom_range(0, 262144)) - 131072;
      my[k] = ((mx[k] * 3) >>> 2) + longint'($urandom_range(0, 4096)) - 2048;
    end
    run("pulse", 1'b1);

    for (int k = 0; k < N; k++) begin
      mx[k] = longint'($urandom_range(0, 2000)) - 1000;
      my[k] = longint'($urandom_range(0, 524288)) - 262144;
    end
    run("b2b_a", 1'b0);
    for (int k = 0; k < N; k++) begin
      mx[k] = longint'($urandom_range(0, 524287)) - 262144;
      my[k] = -((mx[k] * 5) >>> 3) + longint'($urandom_range(0, 20000)) - 10000;
    end
    run("b2b_b", 1'b0);

    for (int k = 0; k < N; k++) begin
      mx[k] = k % 2;
      my[k] = (k % 2 == 1) ? SMAX : SMIN;
    end
    run("satb1", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
